dm_access_unit: RTL and testbench

//  Data-memory access stage, downstream of the processor's 16-bit shared bus.

---
 rtl/dm_access_unit.sv | 103 ++++++++++
 tb/tb_dm_access_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// Data-memory access stage: latches AR from the shared bus and runs single
// read/write transactions against a fixed-latency BRAM. Optional macro: DM_ADDR_INC_EN.
module dm_access_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] busout,
    input  logic              load_ar,
    input  logic              rd_req,
    input  logic              wr_req,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] AR,
    output logic [DATA_W-1:0] DM,
    output logic              busy,
    output logic              done
);
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              dm_ld;
    logic              accept;
    logic [ADDR_W-1:0] eff;

    // Bus address bypasses AR so load_ar and a request can share a cycle.
    assign eff    = load_ar ? busout[ADDR_W-1:0] : AR;
    assign accept = (state_q == IDLE) && (rd_req || wr_req);
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == FINISH);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dm_ld   = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_req)      state_d = WR_ISSUE;
                else if (rd_req) state_d = RD_ISSUE;
            end
            RD_ISSUE: begin
                state_d = RD_WAIT;
                cnt_d   = CW'(RD_LAT - 1);
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    dm_ld   = 1'b1;
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_ISSUE: state_d = FINISH;
            FINISH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            AR        <= '0;
            DM        <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Strobes are registered from next state so they line up with the ISSUE cycle.
            mem_en  <= (state_d == RD_ISSUE) || (state_d == WR_ISSUE);
            mem_we  <= (state_d == WR_ISSUE);
            if (accept)
                mem_addr <= eff;
            if ((state_q == IDLE) && wr_req)
                mem_wdata <= busout;
            if (dm_ld)
                DM <= mem_rdata;
            if ((state_q == IDLE) && load_ar)
                AR <= busout[ADDR_W-1:0];
`ifdef DM_ADDR_INC_EN
            else if (state_q == FINISH)
                AR <= AR + ADDR_W'(1);
`endif
        end
    end
endmodule

// File: tb/tb_dm_access_unit.sv
// Randomized scoreboard bench for dm_access_unit with a behavioural memory/address model.
module tb_dm_access_unit;
    parameter int RD_LAT = 1;
    localparam int AW = 8;
    localparam int DW = 16;

    logic          clock, reset_n;
    logic [DW-1:0] busout;
    logic          load_ar, rd_req, wr_req;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [AW-1:0] AR;
    logic [DW-1:0] DM;
    logic          busy, done;

    dm_access_unit #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
        .clock(clock), .reset_n(reset_n), .busout(busout), .load_ar(load_ar),
        .rd_req(rd_req), .wr_req(wr_req), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .AR(AR), .DM(DM), .busy(busy), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // BRAM model: rdata valid RD_LAT cycles after the enable cycle, junk otherwise.
    logic [DW-1:0] tb_mem [256];
    logic [DW-1:0] dpipe  [RD_LAT];
    logic          vpipe  [RD_LAT];
    logic [DW-1:0] junk;
    initial begin
        junk = '0;
        for (int i = 0; i < RD_LAT; i++) begin vpipe[i] = 1'b0; dpipe[i] = '0; end
    end
    always @(posedge clock) begin
        junk <= DW'($urandom);
        if (mem_en && mem_we) tb_mem[mem_addr] <= mem_wdata;
        dpipe[0] <= tb_mem[mem_addr];
        vpipe[0] <= mem_en && !mem_we;
        for (int i = 1; i < RD_LAT; i++) begin
            dpipe[i] <= dpipe[i-1];
            vpipe[i] <= vpipe[i-1];
        end
    end
    assign mem_rdata = vpipe[RD_LAT-1] ? dpipe[RD_LAT-1] : junk;

    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } op_t;
    typedef struct { logic rd; int at; logic [DW-1:0] dm; } dn_t;
    op_t op_q[$];
    dn_t dn_q[$];

    logic [DW-1:0] ref_mem [256];
    logic [AW-1:0] ref_ar;
    logic [DW-1:0] ref_dm;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every memory strobe and every done pulse must match a queued expectation.
    always @(negedge clock) begin
        if (reset_n) begin
            if (mem_en) begin
                if (op_q.size() == 0) chk("unexpected_mem_en", 32'(mem_en), 32'd0);
                else begin
                    op_t o;
                    o = op_q.pop_front();
                    chk("mem_we", 32'(mem_we), 32'(o.we));
                    chk("mem_addr", 32'(mem_addr), 32'(o.addr));
                    if (o.we) chk("mem_wdata", 32'(mem_wdata), 32'(o.wdata));
                end
            end
            if (done) begin
                if (dn_q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
                else begin
                    dn_t d;
                    d = dn_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(d.at));
                    chk(d.rd ? "dm_read" : "dm_after_write", 32'(DM), 32'(d.dm));
                end
            end
        end
    end

    task automatic bump_ar();
`ifdef DM_ADDR_INC_EN
        ref_ar = ref_ar + 8'd1;
`endif
    endtask

    // Issue one request from idle (called #1 after a rising edge), then ride out the
    // transaction while pulsing ignored requests, checking AR stays put.
    task automatic issue(input logic la, input logic rd, input logic wr, input logic [DW-1:0] bus);
        logic [AW-1:0] eff, txn_ar;
        eff = la ? bus[AW-1:0] : ref_ar;
        if (la) ref_ar = bus[AW-1:0];
        txn_ar = ref_ar;
        if (wr) begin
            op_q.push_back('{1'b1, eff, bus});
            ref_mem[eff] = bus;
            dn_q.push_back('{1'b0, cyc + 2, ref_dm});
            bump_ar();
        end else if (rd) begin
            op_q.push_back('{1'b0, eff, '0});
            ref_dm = ref_mem[eff];
            dn_q.push_back('{1'b1, cyc + 2 + RD_LAT, ref_dm});
            bump_ar();
        end
        busout = bus; load_ar = la; rd_req = rd; wr_req = wr;
        @(posedge clock); #1;
        load_ar = 0; rd_req = 0; wr_req = 0; busout = DW'($urandom);
        for (int k = 0; k < 20 && busy; k++) begin
            if ($urandom_range(1, 0) == 1) begin
                load_ar = 1'($urandom); rd_req = 1'($urandom); wr_req = 1'($urandom);
            end
            @(negedge clock);
            chk("ar_stable_busy", 32'(AR), 32'(txn_ar));
            @(posedge clock); #1;
            load_ar = 0; rd_req = 0; wr_req = 0; busout = DW'($urandom);
        end
        if (busy) chk("txn_timeout", 32'(busy), 32'd0);
        chk("ar_idle", 32'(AR), 32'(ref_ar));
    endtask

    initial begin
        reset_n = 0; busout = '0; load_ar = 0; rd_req = 0; wr_req = 0;
        ref_ar = '0; ref_dm = '0;
        for (int i = 0; i < 256; i++) begin
            tb_mem[i] = DW'($urandom);
            ref_mem[i] = tb_mem[i];
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_outs", {mem_en, mem_we, busy, done, mem_addr, AR}, 32'd0);
        chk("rst_data", {mem_wdata, DM}, 32'd0);
        @(posedge clock); #1;
        reset_n = 1;
        @(posedge clock); #1;

        issue(1, 0, 0, 16'h0012);
        issue(0, 0, 1, 16'hBEEF);
        issue(1, 1, 0, 16'h0012);
        chk("dm_beef", 32'(DM), 32'h0000BEEF);
        issue(1, 1, 1, 16'h0034);
        issue(1, 0, 1, 16'h00FF);
        issue(0, 1, 0, 16'h5555);

        // Asynchronous reset in the middle of RD_WAIT.
        busout = 16'h0012; load_ar = 1; rd_req = 1;
        op_q.push_back('{1'b0, 8'h12, '0});
        @(posedge clock); #1;
        load_ar = 0; rd_req = 0;
        @(posedge clock); #1;
        reset_n = 0;
        #1;
        chk("midrst_outs", {mem_en, mem_we, busy, done, mem_addr, AR}, 32'd0);
        chk("midrst_data", {mem_wdata, DM}, 32'd0);
        op_q.delete(); dn_q.delete();
        ref_ar = '0; ref_dm = '0;
        @(posedge clock); #1;
        reset_n = 1;
        repeat (4) begin
            @(negedge clock);
            chk("post_rst_idle", {30'd0, busy, done}, 32'd0);
        end
        @(posedge clock); #1;

        for (int t = 0; t < 150; t++)
            issue(1'($urandom), 1'($urandom), 1'($urandom), DW'($urandom));

        repeat (3) @(posedge clock);
        chk("op_q_empty", 32'(op_q.size()), 32'd0);
        chk("dn_q_empty", 32'(dn_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
